// File: rtl/block_check_wb_pkg.sv
// Shared constants and types for the WB burst-slave checker.
// CTI/BTE codes, FSM states and status bit positions.
package block_check_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int STS_ERR_LSB     = 0;
  localparam int STS_BURST_LSB   = 16;
  localparam int STS_ADDR_ERR    = 32;
  localparam int STS_CTI_ERR     = 33;
  localparam int STS_SEL_BTE_ERR = 34;
  localparam int STS_SHORT       = 35;
  localparam int STS_OVERRUN     = 36;

endpackage

// File: rtl/block_check_wb_burst_slave_mc_if.sv
// Wishbone burst write bus between DMA master and checker.
// master drives the request, slave answers ack/err/rty.
interface block_check_wb_burst_slave_mc_if
  import block_check_wb_pkg::*;
#(
  parameter int DW = 64,
  parameter int AW = 12
);
  logic [AW-1:0]   addr;
  logic [DW-1:0]   data;
  logic [DW/8-1:0] sel;
  logic            we;
  logic            cyc;
  logic            stb;
  logic [2:0]      cti;
  logic [1:0]      bte;
  logic            ack;
  logic            err;
  logic            rty;

  modport master (
    output addr, data, sel, we, cyc, stb, cti, bte,
    input  ack, err, rty
  );

  modport slave (
    input  addr, data, sel, we, cyc, stb, cti, bte,
    output ack, err, rty
  );
endinterface

// File: rtl/block_check_wb_status.sv
// Error/burst counters and sticky flags for config readback.
// Clear is a level and overrides any same-cycle event.
module block_check_wb_status
  import block_check_wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        err_ev,
  input  logic        good_ev,
  input  logic        addr_ev,
  input  logic        cti_ev,
  input  logic        sel_bte_ev,
  input  logic        short_ev,
  input  logic        ovr_ev,
  output logic [39:0] ov_status
);
  logic [15:0] err_cnt;
  logic [15:0] burst_cnt;
  logic [4:0]  flags;
  logic [4:0]  flag_ev;

  assign flag_ev = {ovr_ev, short_ev, sel_bte_ev,
                    cti_ev, addr_ev};

  // saturating err count, wrapping burst count, sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt   <= '0;
      burst_cnt <= '0;
      flags     <= '0;
    end else if (clr) begin
      err_cnt   <= '0;
      burst_cnt <= '0;
      flags     <= '0;
    end else begin
      if (err_ev && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
      if (good_ev)
        burst_cnt <= burst_cnt + 16'd1;
      flags <= flags | flag_ev;
    end
  end

  // pack the readback word
  always_comb begin
    ov_status = '0;
    ov_status[STS_ERR_LSB +: 16]   = err_cnt;
    ov_status[STS_BURST_LSB +: 16] = burst_cnt;
    ov_status[STS_ADDR_ERR]        = flags[0];
    ov_status[STS_CTI_ERR]         = flags[1];
    ov_status[STS_SEL_BTE_ERR]     = flags[2];
    ov_status[STS_SHORT]           = flags[3];
    ov_status[STS_OVERRUN]         = flags[4];
  end
endmodule

// File: rtl/block_check_wb_burst_slave_mc.sv
// Write-only WB burst slave that checks every beat.
// Bad beats get ERR; good data goes to TEST_CHECK.
module block_check_wb_burst_slave_mc
  import block_check_wb_pkg::*;
#(
  parameter int DW        = 64,
  parameter int AW        = 12,
  parameter int BURST_LEN = 512,
  parameter int ADDR_INCR = 0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  block_check_wb_burst_slave_mc_if.slave wbs,
  input  logic [15:0]   iv_control,
  output logic [DW-1:0] ov_test_check_data,
  output logic          o_test_check_data_ena,
  output logic [39:0]   ov_status
);
  localparam int BY = DW / 8;
  localparam int NW = $clog2(BURST_LEN + 1);
  localparam logic [NW-1:0] LAST = NW'(BURST_LEN - 1);
  localparam logic [2:0] MID_CTI =
    (ADDR_INCR != 0) ? CTI_INCR : CTI_CONST;

  state_t        state;
  state_t        nxt;
  logic [NW-1:0] n;
  logic [2:0]    wc;
  logic [2:0]    w;
  logic          burst_err;
  logic          req;
  logic          resp;
  logic          last;
  logic          in_done;
  logic          bad;
  logic          addr_bad;
  logic          cti_bad;
  logic          sb_bad;
  logic [AW-1:0] exp_addr;
  logic [2:0]    exp_cti;
  logic          good_ev;
  logic          short_ev;
  logic [10:0]   unused_ctrl;

  assign unused_ctrl = iv_control[15:5];
  assign w    = iv_control[4:2];
  assign req  = wbs.cyc & wbs.stb & wbs.we
              & iv_control[0];
  assign resp = i_rst_n & req & (wc == w);

  assign exp_addr = (ADDR_INCR != 0)
                  ? AW'(32'(n) * BY) : '0;
  assign last     = (n == LAST);
  assign exp_cti  = last ? CTI_EOB : MID_CTI;
  assign in_done  = (state == ST_DONE);
  assign addr_bad = (wbs.addr != exp_addr);
  assign cti_bad  = (wbs.cti != exp_cti);
  assign sb_bad   = (wbs.sel != '1)
                  | (wbs.bte != BTE_LINEAR);
  assign bad = in_done | addr_bad | cti_bad | sb_bad;

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= nxt;
  end

  // next state; a dropped cyc always returns to idle
  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:  if (req) nxt = ST_BURST;
      ST_BURST: if (resp && last) nxt = ST_DONE;
      ST_DONE:  nxt = ST_DONE;
      default:  nxt = ST_IDLE;
    endcase
    if (!wbs.cyc) nxt = ST_IDLE;
  end

  // beat response
  always_comb begin
    wbs.ack = resp & ~bad;
    wbs.err = resp & bad;
    wbs.rty = 1'b0;
  end

  // beat index, wait count and per-burst error memory
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      n         <= '0;
      wc        <= '0;
      burst_err <= 1'b0;
    end else begin
      if (!wbs.cyc) begin
        n         <= '0;
        burst_err <= 1'b0;
      end else if (resp && !in_done) begin
        n <= n + NW'(1);
        if (bad) burst_err <= 1'b1;
      end
      if (!wbs.cyc || !wbs.stb || resp)
        wc <= '0;
      else if (req)
        wc <= wc + 3'd1;
    end
  end

  // forward accepted data one cycle after ack
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ov_test_check_data    <= '0;
      o_test_check_data_ena <= 1'b0;
    end else begin
      o_test_check_data_ena <= wbs.ack;
      if (wbs.ack) ov_test_check_data <= wbs.data;
    end
  end

  assign good_ev  = (state == ST_BURST) & resp & last
                  & ~bad & ~burst_err;
  assign short_ev = (state == ST_BURST) & ~wbs.cyc
                  & (n != '0);

  block_check_wb_status u_status (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .clr        (iv_control[1]),
    .err_ev     (wbs.err),
    .good_ev    (good_ev),
    .addr_ev    (wbs.err & ~in_done & addr_bad),
    .cti_ev     (wbs.err & ~in_done & cti_bad),
    .sel_bte_ev (wbs.err & ~in_done & sb_bad),
    .short_ev   (short_ev),
    .ovr_ev     (wbs.err & in_done),
    .ov_status  (ov_status)
  );
endmodule

// File: tb/tb_block_check_wb_burst_slave_mc.sv
// Bench for the WB burst checker: two DUTs (const/incr
// address), table vectors, directed and random bursts.
module tb_block_check_wb_burst_slave_mc;
  localparam int LEN = 512;

  logic        clk;
  logic        rst_n;
  bit          dsel;
  logic [11:0] addr;
  logic [63:0] data;
  logic [7:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [15:0] ctrl;

  logic [63:0] data0, data1, dout;
  logic        ena0, ena1, ena;
  logic [39:0] st0, st1, st;
  logic        ack, err, rty;

  block_check_wb_burst_slave_mc_if #(.DW(64), .AW(12)) i0 ();
  block_check_wb_burst_slave_mc_if #(.DW(64), .AW(12)) i1 ();

  assign i0.addr = addr; assign i1.addr = addr;
  assign i0.data = data; assign i1.data = data;
  assign i0.sel  = sel;  assign i1.sel  = sel;
  assign i0.we   = we;   assign i1.we   = we;
  assign i0.cti  = cti;  assign i1.cti  = cti;
  assign i0.bte  = bte;  assign i1.bte  = bte;
  assign i0.cyc  = cyc & ~dsel;
  assign i1.cyc  = cyc & dsel;
  assign i0.stb  = stb & ~dsel;
  assign i1.stb  = stb & dsel;

  assign ack  = dsel ? i1.ack : i0.ack;
  assign err  = dsel ? i1.err : i0.err;
  assign rty  = dsel ? i1.rty : i0.rty;
  assign ena  = dsel ? ena1 : ena0;
  assign dout = dsel ? data1 : data0;
  assign st   = dsel ? st1 : st0;

  block_check_wb_burst_slave_mc #(
    .DW(64), .AW(12), .BURST_LEN(LEN), .ADDR_INCR(0)
  ) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .wbs(i0.slave),
    .iv_control(ctrl), .ov_test_check_data(data0),
    .o_test_check_data_ena(ena0), .ov_status(st0)
  );

  block_check_wb_burst_slave_mc #(
    .DW(64), .AW(12), .BURST_LEN(LEN), .ADDR_INCR(1)
  ) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .wbs(i1.slave),
    .iv_control(ctrl), .ov_test_check_data(data1),
    .o_test_check_data_ena(ena1), .ov_status(st1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int          m_n;
  bit          m_done;
  bit          m_berr;
  int          m_errcnt;
  int          m_bursts;
  logic [4:0]  m_flags;
  logic [63:0] q[$];
  int          exp_pulses = 0;
  int          ena_cnt = 0;

  typedef struct {
    int          w;
    logic [11:0] a;
    logic [2:0]  c;
    logic [7:0]  s;
    logic [1:0]  b;
    bit          e;
    logic [4:0]  f;
  } vec_t;
  vec_t tv[10];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ena) begin
      logic [63:0] e;
      ena_cnt++;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL fwd_unexpected act=1 exp=0");
      end else begin
        e = q.pop_front();
        if (dout !== e) begin
          failures++;
          $display("FAIL fwd_data act=%0h exp=%0h", dout, e);
        end
      end
    end
  end

  function automatic logic [11:0] eaddr(input int i);
    return dsel ? 12'((i * 8) % 4096) : 12'd0;
  endfunction

  function automatic logic [2:0] ecti(input int i);
    if (i == LEN - 1) return 3'b111;
    return dsel ? 3'b010 : 3'b001;
  endfunction

  task automatic zero_model();
    m_errcnt = 0;
    m_bursts = 0;
    m_flags  = '0;
  endtask

  task automatic chk_status(input string nm);
    chk(nm, {24'd0, st},
        {24'd0, 3'b000, m_flags,
         16'(m_bursts), 16'(m_errcnt)});
  endtask

  task automatic clr_status();
    ctrl[1] = 1'b1;
    @(posedge clk); #1;
    ctrl[1] = 1'b0;
    zero_model();
  endtask

  task automatic beat_raw(input logic [11:0] a,
                          input logic [2:0] c,
                          input logic [7:0] s,
                          input logic [1:0] b,
                          input logic [63:0] d,
                          input int w, input int st_at,
                          input int st_len,
                          output bit r_err);
    int reqs;
    bit done;
    bit stalled;
    addr = a; cti = c; sel = s; bte = b; data = d;
    ctrl[4:2] = 3'(w);
    cyc = 1'b1;
    reqs = 0; done = 0; stalled = 0; r_err = 0;
    for (int k = 0; k < 64 && !done; k++) begin
      stb = 1'b1;
      if (st_len > 0 && !stalled && reqs == st_at) begin
        stb = 1'b0;
        repeat (st_len) begin
          @(negedge clk);
          chk("stall_quiet", {ack, err}, 2'b00);
          @(posedge clk); #1;
        end
        stb = 1'b1;
        reqs = 0;
        stalled = 1;
      end
      @(negedge clk);
      if (reqs < w) begin
        chk($sformatf("wait_state m=%0d", m_n),
            {ack, err}, 2'b00);
      end else begin
        chk($sformatf("resp_due m=%0d", m_n),
            ack | err, 1'b1);
        chk("ack_err_excl", ack & err, 1'b0);
        r_err = err;
        done = 1;
      end
      reqs++;
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout act=none exp=resp");
    end
  endtask

  task automatic beat_m(input logic [11:0] a,
                        input logic [2:0] c,
                        input logic [7:0] s,
                        input logic [1:0] b,
                        input int w, input int st_at,
                        input int st_len, input bit clr_now,
                        output bit got);
    logic [63:0] d;
    bit ea, ec, es, eo, e;
    d  = {$urandom, $urandom};
    eo = m_done;
    ea = !m_done && (a != eaddr(m_n));
    ec = !m_done && (c != ecti(m_n));
    es = !m_done && (s != 8'hFF || b != 2'b00);
    e  = eo | ea | ec | es;
    ctrl[1] = clr_now;
    beat_raw(a, c, s, b, d, w, st_at, st_len, got);
    ctrl[1] = 1'b0;
    chk($sformatf("beat_kind n=%0d", m_n), got, e);
    if (!e) begin
      q.push_back(d);
      exp_pulses++;
    end
    if (clr_now) begin
      zero_model();
    end else if (e) begin
      if (m_errcnt < 65535) m_errcnt++;
      m_flags = m_flags | {eo, 1'b0, es, ec, ea};
    end
    if (!m_done) begin
      if (e) m_berr = 1;
      m_n++;
      if (m_n == LEN) begin
        m_done = 1;
        if (!m_berr && !clr_now)
          m_bursts = (m_bursts + 1) % 65536;
      end
    end
  endtask

  task automatic end_burst();
    cyc = 1'b0;
    stb = 1'b0;
    @(negedge clk);
    chk("idle_quiet", {ack, err}, 2'b00);
    @(posedge clk); #1;
    if (!m_done && m_n > 0) m_flags[3] = 1'b1;
    m_n = 0; m_done = 0; m_berr = 0;
  endtask

  task automatic burst(input int w, input int nb,
                       input int bad_cti,
                       input int bad_addr,
                       input int stall_beat,
                       input int st_at, input int st_len);
    bit g;
    for (int i = 0; i < nb; i++) begin
      logic [11:0] a;
      logic [2:0]  c;
      a = eaddr(i) ^ ((i == bad_addr) ? 12'h008 : 12'h000);
      c = (i == bad_cti) ? 3'b111 : ecti(i);
      beat_m(a, c, 8'hFF, 2'b00, w,
             (i == stall_beat) ? st_at : 0,
             (i == stall_beat) ? st_len : 0, 1'b0, g);
    end
  endtask

  initial begin
    bit g;
    int e0;
    rst_n = 1'b0; dsel = 0;
    cyc = 0; stb = 0; we = 1; addr = '0; data = '0;
    sel = 8'hFF; cti = '0; bte = '0; ctrl = 16'h0001;
    zero_model();
    m_n = 0; m_done = 0; m_berr = 0;

    tv[0] = '{0, 12'h000, 3'b010, 8'hFF, 2'b00, 1'b0, 5'b00000};
    tv[1] = '{2, 12'h000, 3'b010, 8'hFF, 2'b00, 1'b0, 5'b00000};
    tv[2] = '{0, 12'h008, 3'b010, 8'hFF, 2'b00, 1'b1, 5'b00001};
    tv[3] = '{1, 12'h000, 3'b001, 8'hFF, 2'b00, 1'b1, 5'b00010};
    tv[4] = '{0, 12'h000, 3'b111, 8'hFF, 2'b00, 1'b1, 5'b00010};
    tv[5] = '{3, 12'h000, 3'b010, 8'h7F, 2'b00, 1'b1, 5'b00100};
    tv[6] = '{0, 12'h000, 3'b010, 8'hFF, 2'b01, 1'b1, 5'b00100};
    tv[7] = '{7, 12'h000, 3'b010, 8'hFF, 2'b00, 1'b0, 5'b00000};
    tv[8] = '{1, 12'h004, 3'b000, 8'hFE, 2'b10, 1'b1, 5'b00111};
    tv[9] = '{0, 12'h000, 3'b010, 8'h00, 2'b00, 1'b1, 5'b00100};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_resp", {ack, err, rty}, 3'b000);
    chk("reset_ena", ena, 1'b0);
    chk("reset_data", dout, 64'd0);
    chk_status("reset_status");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    dsel = 1;
    foreach (tv[i]) begin
      clr_status();
      beat_m(tv[i].a, tv[i].c, tv[i].s, tv[i].b,
             tv[i].w, 0, 0, 1'b0, g);
      chk($sformatf("tv%0d_err", i), g, tv[i].e);
      chk($sformatf("tv%0d_flags", i), st[36:32], tv[i].f);
      chk($sformatf("tv%0d_errcnt", i), st[15:0],
          16'(tv[i].e));
      end_burst();
    end

    clr_status();
    ctrl[0] = 1'b0;
    addr = '0; cti = 3'b010; sel = 8'hFF; bte = '0;
    cyc = 1'b1; stb = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("enable_off_quiet", {ack, err}, 2'b00);
      @(posedge clk); #1;
    end
    ctrl[0] = 1'b1;
    beat_m(12'h000, 3'b010, 8'hFF, 2'b00, 2, 0, 0, 1'b0, g);
    beat_m(12'h008, 3'b010, 8'hFF, 2'b00, 0, 0, 0, 1'b0, g);
    end_burst();
    chk_status("enable_status");

    dsel = 0;
    clr_status();
    e0 = ena_cnt;
    burst(0, LEN, -1, -1, -1, 0, 0);
    chk("t1_rty", rty, 1'b0);
    end_burst();
    chk("t1_ena_pulses", 64'(ena_cnt - e0), 64'd512);
    chk("t1_bursts", st[31:16], 16'd1);
    chk_status("t1_status");

    dsel = 1;
    clr_status();
    burst(3, LEN, -1, -1, 10, 2, 5);
    end_burst();
    chk_status("t2_status");

    clr_status();
    e0 = ena_cnt;
    burst(0, LEN, 100, 200, -1, 0, 0);
    end_burst();
    chk("t3_ena_pulses", 64'(ena_cnt - e0), 64'd510);
    chk("t3_errcnt", st[15:0], 16'd2);
    chk("t3_flags", st[36:32], 5'b00011);
    chk("t3_bursts", st[31:16], 16'd0);
    chk_status("t3_status");

    dsel = 0;
    clr_status();
    burst(1, 300, -1, -1, -1, 0, 0);
    end_burst();
    chk("t4_short", st[35], 1'b1);
    burst(0, LEN, -1, -1, -1, 0, 0);
    chk("t4_bursts", st[31:16], 16'd1);

    beat_m(12'h000, 3'b001, 8'hFF, 2'b00, 0, 0, 0, 1'b0, g);
    chk("t5_overrun_err", g, 1'b1);
    chk("t5_overrun_flag", st[36], 1'b1);
    chk_status("t5_status");
    end_burst();

    dsel = 1;
    clr_status();
    beat_m(12'h010, 3'b010, 8'hFF, 2'b00, 0, 0, 0, 1'b1, g);
    chk("t6_err", g, 1'b1);
    chk("t6_errcnt", st[15:0], 16'd0);
    chk_status("t6_status");
    end_burst();
    chk_status("t6_status_end");

    for (int r = 0; r < 4; r++) begin
      int w, nb;
      dsel = r[0];
      clr_status();
      w  = $urandom_range(0, 3);
      nb = ($urandom_range(0, 3) == 0)
         ? $urandom_range(1, LEN - 1) : LEN;
      for (int i = 0; i < nb; i++) begin
        logic [11:0] a;
        logic [2:0]  c;
        logic [7:0]  s;
        logic [1:0]  b;
        int sa, sl;
        a = eaddr(i); c = ecti(i); s = 8'hFF; b = 2'b00;
        sa = 0; sl = 0;
        if ($urandom_range(0, 63) == 0) begin
          case ($urandom_range(0, 3))
            0: a = a ^ 12'(1 << $urandom_range(0, 11));
            1: c = 3'($urandom);
            2: s = 8'($urandom);
            default: b = 2'($urandom);
          endcase
        end
        if (w > 0 && $urandom_range(0, 31) == 0) begin
          sa = $urandom_range(0, w - 1);
          sl = $urandom_range(1, 4);
        end
        beat_m(a, c, s, b, w, sa, sl, 1'b0, g);
      end
      if (m_done && $urandom_range(0, 1) == 1)
        beat_m(12'h000, 3'b111, 8'hFF, 2'b00, w, 0, 0,
               1'b0, g);
      chk_status($sformatf("rand%0d_status", r));
      end_burst();
      chk_status($sformatf("rand%0d_status_end", r));
    end

    dsel = 1;
    clr_status();
    burst(0, 50, -1, -1, -1, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_resp", {ack, err, rty}, 3'b000);
    chk("rst_ena", ena, 1'b0);
    chk("rst_data", dout, 64'd0);
    chk("rst_status", st, 40'd0);
    exp_pulses = exp_pulses - q.size();
    q.delete();
    zero_model();
    m_n = 0; m_done = 0; m_berr = 0;
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    burst(0, LEN, -1, -1, -1, 0, 0);
    chk_status("rst_after_status");
    end_burst();

    chk("ena_total", 64'(ena_cnt), 64'(exp_pulses));
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/block_check_wb_burst_slave_mc.md
# block_check_wb_burst_slave_mc

Parametrised write-only Wishbone burst-slave checker for DS_DMA test paths. It accepts linear bursts of configurable length, data width and address mode, and inserts programmable ACK wait states. Every beat's address, SEL, BTE and CTI is checked, and a failing beat is answered with ERR instead of ACK. Accepted data is forwarded to the TEST_CHECK datapath, and sticky status plus error and burst counters are kept for the WBS_CFG readback.

## Interface
- DW, 64: data width; multiple of 8, from 8 to 256.
- AW, 12: byte-address width.
- BURST_LEN, 512: beats per burst; at least 2.
- ADDR_INCR, 0: 0 selects a constant-address burst (CTI 001, address always 0); 1 selects an incrementing burst (CTI 010, address steps by DW/8 modulo 2^AW).
- i_clk, in, 1: sole clock.
- i_rst_n, in, 1: asynchronous, active-low reset.
- iv_wbs_burst_addr, in, AW: byte address.
- iv_wbs_burst_data, in, DW: write data.
- iv_wbs_burst_sel, in, DW/8: byte selects; must be all ones.
- i_wbs_burst_we / i_wbs_burst_cyc / i_wbs_burst_stb, in, 1 each: WB strobes.
- iv_wbs_burst_cti, in, 3: cycle-type identifier.
- iv_wbs_burst_bte, in, 2: burst-type extension; must be 00.
- o_wbs_burst_ack, out, 1: beat accepted.
- o_wbs_burst_err, out, 1: beat rejected.
- o_wbs_burst_rty, out, 1: tied to 0.
- ov_test_check_data, out, DW: accepted data.
- o_test_check_data_ena, out, 1: qualifies ov_test_check_data.
- iv_control, in, 16: bit0 enable; bit1 clear status (level); bits4:2 wait states W (0–7); other bits reserved.
- ov_status, out, 40: [15:0] err_count, saturating; [31:16] good-burst count, wrapping; [36:32] sticky flags addr_err, cti_err, sel_bte_err, short_burst, overrun; [39:37] zero.

## Operation
- Request cycle: cyc & stb & we & enable. Without enable, no ACK or ERR is issued and the FSM holds in IDLE.
- FSM states and transitions:
  - IDLE: the first request cycle moves to BURST with beat index n = 0.
  - BURST: each response increments n. After the response to beat BURST_LEN-1, go to DONE.
  - DONE: waits for cyc to fall, then returns to IDLE.
  - Any state: cyc low forces IDLE.
- Short burst: cyc falls while in BURST with 0 < n < BURST_LEN. Set short_burst.
- Wait counter wc:
  - Increments while a request cycle is active and no response has been given yet.
  - Clears on a response, when stb falls (master stall), or when cyc falls.
  - A response is given when wc == W.
- Response is ERR if any check below fails; otherwise ACK. ACK and ERR are never asserted together.
  - Address: expected = ADDR_INCR ? n*(DW/8) mod 2^AW : 0. Mismatch sets addr_err.
  - SEL and BTE: SEL not all ones, or BTE not 00, sets sel_bte_err.
  - CTI: n < BURST_LEN-1 must use 001 or 010 per ADDR_INCR; n == BURST_LEN-1 must use 111. Mismatch sets cti_err.
  - Overrun: a request cycle in DONE always gets ERR and sets overrun.
- Errored beats still advance n, so the burst stays aligned.
- err_count increments on every ERR response, saturating at FFFF.
- Good-burst count increments on entry to DONE, but only if the burst had no ERR.
- Data forwarding: on ACK, data is registered; on ERR, data is dropped.
- Status clear: while iv_control[1] = 1, the counters and flags are held at 0. Clear wins over a same-cycle increment.
- Reset: asynchronous. Reset mid-burst aborts the burst with no flags set.

## Timing
- ACK/ERR are combinational from the inputs and registered state.
  - W = 0: response in the same cycle as stb, giving single-cycle beats.
  - W = k: response on the (k+1)th consecutive request cycle.
- o_test_check_data_ena and data: one cycle after ACK.
- Status registers update on the clock edge following the response or event.
- Reset values: all outputs 0; FSM = IDLE; n = 0; wc = 0.
- Changing W mid-beat takes effect immediately in the comparison with wc.

## Structure
- Shared package block_check_wb_pkg holds:
  - CTI constants: CLASSIC 000, CONST 001, INCR 010, EOB 111.
  - BTE_LINEAR constant.
  - FSM state typedef.
  - Status bit-index constants.
- Sub-module block_check_wb_status holds the counters and sticky flags. Its inputs are event strobes and clear; its output is ov_status.

## Test plan
- Constant-address mode, DW=64, BURST_LEN=512, W=0, clean burst → 512 single-cycle ACKs, 512 ena pulses, burst count 1, err_count 0.
- ADDR_INCR=1, W=3, master stall of 5 cycles on beat 10 → every ACK arrives exactly 4 request cycles after stb rises; beat 10's wait count restarts after the stall; no flags set.
- CTI=111 on beat 100 and wrong address on beat 200 → ERR on exactly those beats; cti_err and addr_err set; err_count 2; burst count stays 0; 510 ena pulses.
- cyc dropped after 300 beats → short_burst set, FSM in IDLE. A subsequent clean burst → burst count 1.
- A 513th beat after EOB → ERR, overrun set.
- Clear asserted in the same cycle as an ERR → err_count reads 0.
- i_rst_n pulsed mid-burst → all outputs 0 immediately. The next burst restarts at n = 0.
